// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: owns the PC, selects the next PC
// (sequential / branch / jump) and registers the fetched word into D.
module fetch_stage #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcM,
    input  logic [WIDTH-1:0] PCBranchM,
    input  logic             JumpD,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic [5:0]       opD,
    output logic [5:0]       functD,
    output logic             ValidD
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-3){1'b0}}, 3'b100};

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] instr_r;
    logic [WIDTH-1:0] pcplus4d_r;
    logic             valid_r;

    logic [WIDTH-1:0] pcplus4f_s;
    logic [WIDTH-1:0] jump_target_s;
    logic [WIDTH-1:0] pc_next_s;
    logic             jump_taken_s;
    logic             bubble_s;

    assign pcplus4f_s    = pc_r + PC_STEP;
    assign jump_target_s = {pcplus4d_r[WIDTH-1:28], instr_r[25:0], 2'b00};
    // A jump held in D by StallD must not redirect until it actually leaves D.
    assign jump_taken_s  = JumpD & ~StallD;
    assign bubble_s      = FlushD | PCSrcM | jump_taken_s;

    // Next-PC selection: the branch in M is older than the jump in D, so it wins.
    always_comb begin
        pc_next_s = pc_r;
        if (PCSrcM) begin
            pc_next_s = PCBranchM;
        end else if (jump_taken_s) begin
            pc_next_s = jump_target_s;
        end else if (StallF) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pcplus4f_s;
        end
    end

    // PC register; every load is forced word-aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC & ALIGN_MASK;
        end else begin
            pc_r <= pc_next_s & ALIGN_MASK;
        end
    end

    // IF/ID register: squashing the wrong-path word takes precedence over holding it.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r    <= {WIDTH{1'b0}};
            pcplus4d_r <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
        end else if (bubble_s) begin
            instr_r    <= {WIDTH{1'b0}};
            pcplus4d_r <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
        end else if (StallD) begin
            instr_r    <= instr_r;
            pcplus4d_r <= pcplus4d_r;
            valid_r    <= valid_r;
        end else begin
            instr_r    <= imem_rdata;
            pcplus4d_r <= pcplus4f_s;
            valid_r    <= 1'b1;
        end
    end

    assign PCF       = pc_r;
    assign imem_addr = pc_r;
    assign InstrD    = instr_r;
    assign PCPlus4D  = pcplus4d_r;
    assign ValidD    = valid_r;
    assign opD       = instr_r[31:26];
    assign functD    = instr_r[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the fetch/IF-ID rules.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcM, JumpD;
    logic [31:0] PCBranchM;
    logic [31:0] imem_addr, imem_rdata, PCF, InstrD, PCPlus4D;
    logic [5:0]  opD, functD;
    logic        ValidD;

    int n_checks = 0;
    int n_fails  = 0;

    // behavioural model state
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4d  = 32'h0;
    logic        m_valid = 1'b0;

    fetch_stage #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .PCSrcM(PCSrcM), .PCBranchM(PCBranchM), .JumpD(JumpD),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .PCF(PCF),
        .InstrD(InstrD), .PCPlus4D(PCPlus4D), .opD(opD), .functD(functD),
        .ValidD(ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a jump at 0x10000000, a hash of the address elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1000_0000) return 32'h0800_0010;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C ^ {a[31:16], a[31:16]};
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("PCF",       PCF,               m_pc);
        check("imem_addr", imem_addr,         m_pc);
        check("InstrD",    InstrD,            m_instr);
        check("PCPlus4D",  PCPlus4D,          m_pc4d);
        check("ValidD",    {31'b0, ValidD},   {31'b0, m_valid});
        check("opD",       {26'b0, opD},      {26'b0, m_instr[31:26]});
        check("functD",    {26'b0, functD},   {26'b0, m_instr[5:0]});
    endtask

    // One clock cycle: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic [31:0] pb, input logic jd);
        logic [31:0] fetched, seq, target, npc;
        logic        jump_now;
        reset = rst; StallF = sf; StallD = sd; FlushD = fd;
        PCSrcM = ps; PCBranchM = pb; JumpD = jd;
        fetched  = mem_word(m_pc);
        seq      = m_pc + 32'd4;
        target   = {m_pc4d[31:28], m_instr[25:0], 2'b00};
        jump_now = jd && !sd;
        if (rst) begin
            m_pc = RESET_PC; m_instr = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
        end else begin
            if (ps)            npc = pb;
            else if (jump_now) npc = target;
            else if (sf)       npc = m_pc;
            else               npc = seq;
            if (fd || ps || jump_now) begin
                m_instr = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
            end else if (!sd) begin
                m_instr = fetched; m_pc4d = seq; m_valid = 1'b1;
            end
            m_pc = {npc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcM = 1'b0; PCBranchM = 32'h0; JumpD = 1'b0;

        // reset and free-running fetch
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("reset_pc", PCF, 32'h0);
        check("reset_valid", {31'b0, ValidD}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("free_pc4", PCF, 32'h4);
        check("free_instr0", InstrD, mem_word(32'h0));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("free_pc8", PCF, 32'h8);

        // stall both stages at 0x8 for two cycles, then release
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_hold_pc", PCF, 32'h8);
        check("stall_hold_pc4d", PCPlus4D, 32'h8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_release_pc", PCF, 32'hC);

        // branch overrides StallF
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        check("branch_pc", PCF, 32'h40);
        check("branch_bubble", InstrD, 32'h0);

        // jump: fetch j at 0x10000000, then redirect
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("jump_instrD", InstrD, 32'h0800_0010);
        check("jump_pc4d", PCPlus4D, 32'h1000_0004);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("jump_pc", PCF, 32'h1000_0040);
        check("jump_valid", {31'b0, ValidD}, 32'h0);

        // jump held by StallD: no redirect until StallD drops
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("jump_stalled_pc", PCF, 32'h1000_0004);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("jump_released_pc", PCF, 32'h1000_0040);

        // FlushD wins over StallD, with and without StallF
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // asymmetric stalls
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // PC wrap and unaligned branch target
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap_pc", PCF, 32'h0);
        check("wrap_pc4d", PCPlus4D, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0123, 1'b0);
        check("align_pc", PCF, 32'h0000_0120);

        // reset beats stall, branch and jump
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
        check("reset_mid_pc", PCF, RESET_PC);
        check("reset_mid_valid", {31'b0, ValidD}, 32'h0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom,
                 ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
